button_debouncer: RTL and testbench

//   Conditions a raw, bouncing push-button input before it drives the latch/flip-flop stages.
//   - Synchronises the input to clock.
//   - Filters contact bounce with a counter-based FSM.
//   - Produces a clean level, one-cycle press/release pulses, and a press-toggled output.
//   - button_out feeds a latch d input; pressed feeds an enable input.

---
 rtl/debouncer_pkg.sv | 17 +
 rtl/sync_chain.sv | 29 ++
 rtl/button_debouncer.sv | 115 +++++++++++
 tb/tb_button_debouncer.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/debouncer_pkg.sv
// Shared types and default constants for the push-button conditioning logic.
//   debounce_state_t  : debounce FSM state encoding
//   DefSyncStages     : default synchroniser depth
//   DefDebounceCycles : default stable-sample count (10 ms at 50 MHz)
package debouncer_pkg;

    typedef enum logic [1:0] {
        STABLE_LOW  = 2'd0,
        WAIT_HIGH   = 2'd1,
        STABLE_HIGH = 2'd2,
        WAIT_LOW    = 2'd3
    } debounce_state_t;

    localparam int unsigned DefSyncStages     = 2;
    localparam int unsigned DefDebounceCycles = 500000;

endpackage

// File: rtl/sync_chain.sv
// Multi-flop synchroniser for an asynchronous single-bit input.
//   clock    : system clock, rising edge
//   reset    : synchronous active-high reset, clears every stage to 0
//   async_in : asynchronous input level
//   sync_out : input level after STAGES flops
module sync_chain
    import debouncer_pkg::*;
#(
    parameter int unsigned STAGES = DefSyncStages  // must be >= 2
) (
    input  logic clock,
    input  logic reset,
    input  logic async_in,
    output logic sync_out
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], async_in};
        end
    end

    assign sync_out = sync_q[STAGES-1];

endmodule

// File: rtl/button_debouncer.sv
// Push-button conditioner: synchronises the raw level, rejects contact bounce with a
// counter-based FSM and produces a clean level, press/release pulses and a toggle.
//   clock      : system clock, rising edge
//   reset      : synchronous active-high reset
//   button_in  : raw asynchronous button level, 1 = pressed
//   button_out : debounced level
//   pressed    : one-cycle pulse on an accepted 0->1 change
//   released   : one-cycle pulse on an accepted 1->0 change
//   toggle_out : inverts on every accepted press
module button_debouncer
    import debouncer_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = DefSyncStages,
    parameter int unsigned DEBOUNCE_CYCLES = DefDebounceCycles
) (
    input  logic clock,
    input  logic reset,
    input  logic button_in,
    output logic button_out,
    output logic pressed,
    output logic released,
    output logic toggle_out
);

    localparam int unsigned     CntW    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

    logic            s;
    debounce_state_t state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            btn_q, btn_d;
    logic            press_q, press_d;
    logic            rel_q, rel_d;
    logic            tog_q, tog_d;

    sync_chain #(
        .STAGES(SYNC_STAGES)
    ) u_sync (
        .clock   (clock),
        .reset   (reset),
        .async_in(button_in),
        .sync_out(s)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        btn_d   = btn_q;
        tog_d   = tog_q;
        press_d = 1'b0;
        rel_d   = 1'b0;
        unique case (state_q)
            STABLE_LOW: begin
                if (s) begin
                    state_d = WAIT_HIGH;
                    cnt_d   = '0;
                end
            end
            WAIT_HIGH: begin
                if (!s) begin
                    state_d = STABLE_LOW;  // bounce: drop back silently
                end else if (cnt_q == CntLast) begin
                    state_d = STABLE_HIGH;
                    btn_d   = 1'b1;
                    tog_d   = ~tog_q;
                    press_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            STABLE_HIGH: begin
                if (!s) begin
                    state_d = WAIT_LOW;
                    cnt_d   = '0;
                end
            end
            WAIT_LOW: begin
                if (s) begin
                    state_d = STABLE_HIGH;
                end else if (cnt_q == CntLast) begin
                    state_d = STABLE_LOW;
                    btn_d   = 1'b0;
                    rel_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: state_d = STABLE_LOW;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= STABLE_LOW;
            cnt_q   <= '0;
            btn_q   <= 1'b0;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
            tog_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            btn_q   <= btn_d;
            press_q <= press_d;
            rel_q   <= rel_d;
            tog_q   <= tog_d;
        end
    end

    assign button_out = btn_q;
    assign pressed    = press_q;
    assign released   = rel_q;
    assign toggle_out = tog_q;

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer (SYNC_STAGES=2, DEBOUNCE_CYCLES=4) plus a second
// instance with DEBOUNCE_CYCLES=1 for the minimum-dwell case.
module tb_button_debouncer;

    logic clock = 1'b0;
    logic reset;
    logic button_in;
    logic button_out, pressed, released, toggle_out;
    logic b1_in;
    logic b1_out, b1_pressed, b1_released, b1_toggle;

    int n_total = 0;
    int n_bad   = 0;
    int n_press = 0;
    int n_rel   = 0;

    always #5 clock = ~clock;

    button_debouncer #(
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .button_in (button_in),
        .button_out(button_out),
        .pressed   (pressed),
        .released  (released),
        .toggle_out(toggle_out)
    );

    button_debouncer #(
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(1)
    ) dut1 (
        .clock     (clock),
        .reset     (reset),
        .button_in (b1_in),
        .button_out(b1_out),
        .pressed   (b1_pressed),
        .released  (b1_released),
        .toggle_out(b1_toggle)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // One clock edge, then sample 1 ns later; tallies pulses and checks exclusivity.
    task automatic step();
        @(posedge clock);
        #1;
        if (pressed === 1'b1) n_press++;
        if (released === 1'b1) n_rel++;
        check_eq("no_coincide", 32'(pressed & released), 32'd0);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic check_outs(input string tag, input logic bo, input logic pr,
                              input logic rl, input logic tg);
        check_eq({tag, "_button_out"}, 32'(button_out), 32'(bo));
        check_eq({tag, "_pressed"},    32'(pressed),    32'(pr));
        check_eq({tag, "_released"},   32'(released),   32'(rl));
        check_eq({tag, "_toggle_out"}, 32'(toggle_out), 32'(tg));
    endtask

    initial begin
        reset     = 1'b1;
        button_in = 1'b1;
        b1_in     = 1'b0;

        // 1. reset held two cycles with the button high
        step();
        check_outs("rst0", 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        check_outs("rst1", 1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        step();
        check_outs("rst_after", 1'b0, 1'b0, 1'b0, 1'b0);
        // one-sample glitch after reset must be rejected
        button_in = 1'b0;
        steps(8);
        check_eq("rst_glitch_press", 32'(n_press), 32'd0);
        check_outs("idle", 1'b0, 1'b0, 1'b0, 1'b0);

        // 2. clean press: pulse visible after edge 6
        n_press   = 0;
        button_in = 1'b1;
        step();            // edge 0
        steps(5);          // edges 1..5
        check_outs("press_e5", 1'b0, 1'b0, 1'b0, 1'b0);
        step();            // edge 6
        check_outs("press_e6", 1'b1, 1'b1, 1'b0, 1'b1);
        step();
        check_outs("press_e7", 1'b1, 1'b0, 1'b0, 1'b1);
        steps(4);
        check_eq("press_count", 32'(n_press), 32'd1);

        // 4. clean release: toggle_out holds
        n_rel     = 0;
        button_in = 1'b0;
        step();
        steps(5);
        check_outs("rel_e5", 1'b1, 1'b0, 1'b0, 1'b1);
        step();
        check_outs("rel_e6", 1'b0, 1'b0, 1'b1, 1'b1);
        step();
        check_outs("rel_e7", 1'b0, 1'b0, 1'b0, 1'b1);
        check_eq("rel_count", 32'(n_rel), 32'd1);

        // 3. bounce 1,1,1,0 then steady 1: single pulse timed from the steady level
        n_press   = 0;
        button_in = 1'b1;
        steps(3);
        button_in = 1'b0;
        step();
        button_in = 1'b1;
        step();            // edge 0 of steady level
        steps(5);
        check_outs("bounce_e5", 1'b0, 1'b0, 1'b0, 1'b1);
        check_eq("bounce_early", 32'(n_press), 32'd0);
        step();
        check_outs("bounce_e6", 1'b1, 1'b1, 1'b0, 1'b0);
        steps(6);
        check_eq("bounce_count", 32'(n_press), 32'd1);
        button_in = 1'b0;
        steps(10);
        check_outs("bounce_rel", 1'b0, 1'b0, 1'b0, 1'b0);

        // 5. two full press/release cycles
        n_press = 0;
        n_rel   = 0;
        for (int k = 0; k < 2; k++) begin
            button_in = 1'b1;
            steps(10);
            button_in = 1'b0;
            steps(10);
        end
        check_eq("cyc_press", 32'(n_press), 32'd2);
        check_eq("cyc_rel", 32'(n_rel), 32'd2);
        check_outs("cyc_end", 1'b0, 1'b0, 1'b0, 1'b0);

        // 6. reset during WAIT_HIGH with counter at 2
        n_press   = 0;
        button_in = 1'b1;
        steps(5);          // edges 0..4: WAIT_HIGH entered at edge 2, counter 2 after edge 4
        reset = 1'b1;
        step();
        check_outs("midrst0", 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        check_outs("midrst1", 1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        step();            // edge 0 after reset
        steps(5);
        check_outs("midrst_e5", 1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("midrst_nopulse", 32'(n_press), 32'd0);
        step();
        check_outs("midrst_e6", 1'b1, 1'b1, 1'b0, 1'b1);

        // DEBOUNCE_CYCLES=1: latency is SYNC_STAGES + 1 = 3 edges
        b1_in = 1'b1;
        steps(3);          // edges 0..2
        check_eq("d1_press_e2", 32'(b1_pressed), 32'd0);
        step();
        check_eq("d1_press_e3", 32'(b1_pressed), 32'd1);
        check_eq("d1_out_e3", 32'(b1_out), 32'd1);
        check_eq("d1_tog_e3", 32'(b1_toggle), 32'd1);
        step();
        check_eq("d1_press_e4", 32'(b1_pressed), 32'd0);
        b1_in = 1'b0;
        steps(3);
        check_eq("d1_rel_e2", 32'(b1_released), 32'd0);
        step();
        check_eq("d1_rel_e3", 32'(b1_released), 32'd1);
        check_eq("d1_out_rel", 32'(b1_out), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
